// File: rtl/jpeg_capture_ctrl.sv
// jpeg_capture_ctrl: moves one JPEG frame (SOI..EOI) from the camera byte
// stream into the word packer and the frame-buffer write port.
// Optional watchdog: define JPEG_CAPTURE_TIMEOUT_EN.

module jpeg_capture_ctrl #(
   parameter int ADDR_W         = 12,
   parameter int DEPTH          = 4096,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              arm_in,
   input  logic              abort_in,
   input  logic              cam_valid_in,
   input  logic [7:0]        cam_byte_in,
   input  logic              word_valid_in,
   input  logic [3:0]        word_strb_in,
   output logic              pack_valid_out,
   output logic [7:0]        pack_byte_out,
   output logic              pack_complete_out,
   output logic              mem_we_out,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic [3:0]        mem_wstrb_out,
   output logic              busy_out,
   output logic              done_out,
   output logic              error_out,
   output logic [ADDR_W+1:0] frame_bytes_out
);

   localparam int CNT_W = ADDR_W + 3;
   localparam logic [CNT_W-1:0] BYTE_LIMIT = CNT_W'(4 * DEPTH);
   localparam logic [ADDR_W:0]  WORD_LIMIT = (ADDR_W+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HUNT,
      S_CAPTURE,
      S_DRAIN,
      S_DISCARD
   } state_t;

   state_t           state_q, state_d;
   logic             prev_ff_q, prev_ff_d;
   logic             wv_q, wv_d;
   logic             good_q, good_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W:0]  addr_q, addr_d;
   logic             pend_q, pend_d;
   logic [7:0]       pend_byte_q, pend_byte_d;
   logic             pend_cmp_q, pend_cmp_d;
   logic             pv_q, pv_d;
   logic [7:0]       pb_q, pb_d;
   logic             pc_q, pc_d;
   logic             we_q, we_d;
   logic [ADDR_W-1:0] maddr_q, maddr_d;
   logic [3:0]       wstrb_q, wstrb_d;
   logic             err_q, err_d;
   logic             done_q, done_d;
   logic [ADDR_W+1:0] fbytes_q, fbytes_d;

   logic word_rise;
   logic soi;
   logic eoi;
   logic tmo;

   assign wv_d      = word_valid_in;
   assign word_rise = word_valid_in & ~wv_q;
   assign soi = cam_valid_in & prev_ff_q & (cam_byte_in == 8'hD8);
   assign eoi = cam_valid_in & prev_ff_q & (cam_byte_in == 8'hD9);

`ifdef JPEG_CAPTURE_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             tmr_run;

   assign tmr_run = (state_q == S_HUNT) | (state_q == S_CAPTURE);
   assign tmo     = tmr_run & ~cam_valid_in & (tmr_q == TMR_LAST);

   // idle-cycle counter, restarted by every camera byte
   always_comb begin
      tmr_d = tmr_q;
      if (!tmr_run || cam_valid_in) begin
         tmr_d = '0;
      end else if (tmr_q != TMR_LAST) begin
         tmr_d = tmr_q + 1'b1;
      end
   end

   // watchdog counter register
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         tmr_q <= '0;
      end else begin
         tmr_q <= tmr_d;
      end
   end
`else
   // watchdog compiled out: never fires
   assign tmo = (TIMEOUT_CYCLES < 0);
`endif

   // next state, packer byte path and frame-buffer write sequencing
   always_comb begin
      state_d     = state_q;
      prev_ff_d   = prev_ff_q;
      good_d      = good_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      done_d      = 1'b0;
      fbytes_d    = fbytes_q;
      pend_d      = 1'b0;
      pend_byte_d = pend_byte_q;
      pend_cmp_d  = pend_cmp_q;
      pv_d        = 1'b0;
      pb_d        = 8'h00;
      pc_d        = 1'b0;

      // the second byte of a two-byte emission leaves one cycle later
      if (pend_q) begin
         pv_d = 1'b1;
         pb_d = pend_byte_q;
         pc_d = pend_cmp_q;
      end

      we_d    = word_rise & (state_q != S_DISCARD);
      maddr_d = we_d ? addr_q[ADDR_W-1:0] : maddr_q;
      wstrb_d = we_d ? word_strb_in : 4'b0000;
      addr_d  = addr_q + {{ADDR_W{1'b0}}, we_d};

      unique case (state_q)
         S_IDLE: begin
            if (arm_in && !abort_in) begin
               state_d   = S_HUNT;
               err_d     = 1'b0;
               cnt_d     = '0;
               addr_d    = '0;
               prev_ff_d = 1'b0;
               good_d    = 1'b0;
            end
         end
         S_HUNT: begin
            if (abort_in) begin
               state_d = S_IDLE;
            end else if (tmo) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (cam_valid_in) begin
               prev_ff_d = (cam_byte_in == 8'hFF);
               if (soi) begin
                  pv_d        = 1'b1;
                  pb_d        = 8'hFF;
                  pend_d      = 1'b1;
                  pend_byte_d = 8'hD8;
                  pend_cmp_d  = 1'b0;
                  cnt_d       = CNT_W'(2);
                  state_d     = S_CAPTURE;
               end
            end
         end
         S_CAPTURE: begin
            if (abort_in || tmo) begin
               if (tmo) begin
                  err_d = 1'b1;
               end
               // pad byte closes the packer's partial word
               if (pend_q) begin
                  pend_d      = 1'b1;
                  pend_byte_d = 8'h00;
                  pend_cmp_d  = 1'b1;
               end else begin
                  pv_d = 1'b1;
                  pb_d = 8'h00;
                  pc_d = 1'b1;
               end
               state_d = S_DISCARD;
            end else if (cam_valid_in) begin
               if (cnt_q == BYTE_LIMIT) begin
                  err_d  = 1'b1;
                  good_d = 1'b0;
                  // last full word may already be written
                  state_d = (addr_d == WORD_LIMIT) ? S_IDLE : S_DRAIN;
               end else begin
                  pv_d      = 1'b1;
                  pb_d      = cam_byte_in;
                  cnt_d     = cnt_q + 1'b1;
                  prev_ff_d = (cam_byte_in == 8'hFF);
                  if (eoi) begin
                     pc_d    = 1'b1;
                     good_d  = 1'b1;
                     state_d = S_DRAIN;
                  end
               end
            end
         end
         S_DRAIN: begin
            if (word_rise) begin
               state_d = S_IDLE;
               if (good_q) begin
                  done_d   = 1'b1;
                  fbytes_d = cnt_q[ADDR_W+1:0];
               end
            end
         end
         S_DISCARD: begin
            if (word_rise) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= S_IDLE;
         prev_ff_q   <= 1'b0;
         wv_q        <= 1'b0;
         good_q      <= 1'b0;
         cnt_q       <= '0;
         addr_q      <= '0;
         pend_q      <= 1'b0;
         pend_byte_q <= 8'h00;
         pend_cmp_q  <= 1'b0;
         pv_q        <= 1'b0;
         pb_q        <= 8'h00;
         pc_q        <= 1'b0;
         we_q        <= 1'b0;
         maddr_q     <= '0;
         wstrb_q     <= 4'b0000;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
         fbytes_q    <= '0;
      end else begin
         state_q     <= state_d;
         prev_ff_q   <= prev_ff_d;
         wv_q        <= wv_d;
         good_q      <= good_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         pend_q      <= pend_d;
         pend_byte_q <= pend_byte_d;
         pend_cmp_q  <= pend_cmp_d;
         pv_q        <= pv_d;
         pb_q        <= pb_d;
         pc_q        <= pc_d;
         we_q        <= we_d;
         maddr_q     <= maddr_d;
         wstrb_q     <= wstrb_d;
         err_q       <= err_d;
         done_q      <= done_d;
         fbytes_q    <= fbytes_d;
      end
   end

   assign pack_valid_out    = pv_q;
   assign pack_byte_out     = pb_q;
   assign pack_complete_out = pc_q;
   assign mem_we_out        = we_q;
   assign mem_addr_out      = maddr_q;
   assign mem_wstrb_out     = wstrb_q;
   assign busy_out          = (state_q != S_IDLE);
   assign done_out          = done_q;
   assign error_out         = err_q;
   assign frame_bytes_out   = fbytes_q;

endmodule

// File: tb/tb_jpeg_capture_ctrl.sv
// tb_jpeg_capture_ctrl: scoreboard bench with a packer model and a
// frame-level reference model of the capture controller.

module tb_jpeg_capture_ctrl;

   localparam int AW    = 5;
   localparam int DEPTH = 16;
   localparam int LIMIT = 4 * DEPTH;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          arm = 1'b0;
   logic          abort = 1'b0;
   logic          cam_valid = 1'b0;
   logic [7:0]    cam_byte = 8'h00;
   logic          word_valid = 1'b0;
   logic [3:0]    word_strb = 4'h0;
   logic          pack_valid;
   logic [7:0]    pack_byte;
   logic          pack_complete;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_wstrb;
   logic          busy;
   logic          done;
   logic          error;
   logic [AW+1:0] frame_bytes;

   int tests = 0;
   int fails = 0;
   int hold  = 2;
   int byte_q[$];
   int wr_q[$];
   int done_q[$];
   int wq[$];
   int stim[$];
   int pk_n;

   always #5 clk = ~clk;

   jpeg_capture_ctrl #(
      .ADDR_W(AW),
      .DEPTH(DEPTH),
      .TIMEOUT_CYCLES(50)
   ) dut (
      .clk_in(clk),
      .rst_n_in(rst_n),
      .arm_in(arm),
      .abort_in(abort),
      .cam_valid_in(cam_valid),
      .cam_byte_in(cam_byte),
      .word_valid_in(word_valid),
      .word_strb_in(word_strb),
      .pack_valid_out(pack_valid),
      .pack_byte_out(pack_byte),
      .pack_complete_out(pack_complete),
      .mem_we_out(mem_we),
      .mem_addr_out(mem_addr),
      .mem_wstrb_out(mem_wstrb),
      .busy_out(busy),
      .done_out(done),
      .error_out(error),
      .frame_bytes_out(frame_bytes)
   );

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic extra(input string nm, input int act);
      tests++;
      fails++;
      $display("FAIL %s: unexpected output 0x%0h, none expected", nm, act);
   endtask

   // monitor: pops expectations whenever the DUT presents an output
   always @(negedge clk) begin
      if (!rst_n) begin
         pk_n = 0;
      end else begin
         if (pack_valid) begin
            if (byte_q.size() == 0)
               extra("pack_byte", int'({pack_complete, pack_byte}));
            else
               chk("pack_byte", int'({pack_complete, pack_byte}),
                   byte_q.pop_front());
            pk_n++;
            if (pk_n == 4 || pack_complete) begin
               wq.push_back((15 << (4 - pk_n)) & 15);
               pk_n = 0;
            end
         end
         if (mem_we) begin
            if (wr_q.size() == 0)
               extra("mem_wr", int'({mem_addr, mem_wstrb}));
            else
               chk("mem_wr", int'({mem_addr, mem_wstrb}),
                   wr_q.pop_front());
         end
         if (done) begin
            if (done_q.size() == 0)
               extra("done", int'(frame_bytes));
            else
               chk("frame_bytes", int'(frame_bytes), done_q.pop_front());
         end
      end
   end

   // packer model: word-valid level held for 'hold' cycles per word
   initial begin : packer
      int s;
      forever begin
         @(negedge clk);
         if (wq.size() > 0 && rst_n) begin
            s = wq.pop_front();
            @(negedge clk);
            word_valid = 1'b1;
            word_strb  = 4'(s);
            repeat (hold) @(negedge clk);
            word_valid = 1'b0;
            word_strb  = 4'h0;
         end
      end
   end

   initial begin : watchdog
      #3000000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

   task automatic mk(input int pre, input int len);
      int b;
      int p;
      stim.delete();
      repeat (pre) stim.push_back(int'($urandom_range(254, 0)));
      stim.push_back('hFF);
      stim.push_back('hD8);
      p = 0;
      for (int i = 0; i < len; i++) begin
         case ($urandom_range(7, 0))
            0: b = 'hFF;
            1: b = 'h00;
            2: b = 'hD8;
            3: b = 'hD9;
            default: b = int'($urandom_range(255, 0));
         endcase
         if (p != 0 && b == 'hD9) b = 'h5A;
         stim.push_back(b);
         p = (b == 'hFF) ? 1 : 0;
      end
      stim.push_back('hFF);
      stim.push_back('hD9);
   endtask

   // reference model on the whole frame, then stimulus, then final checks
   task automatic run_frame(input int abort_at, input int gmin,
                            input int gmax, input int arm_mid);
      int fwd[$];
      int n;
      int lim;
      int nw;
      int b;
      int g;
      int c;
      int strb;
      bit cap;
      bit prev;
      bit good;
      bit ovf;
      bit ab;
      n = 0; cap = 0; prev = 0; good = 0; ovf = 0;
      ab  = (abort_at >= 0);
      lim = ab ? abort_at : stim.size();
      for (int i = 0; i < lim; i++) begin
         b = stim[i];
         if (!cap) begin
            if (prev && b == 'hD8) begin
               fwd.push_back('hFF);
               fwd.push_back('hD8);
               n = 2;
               cap = 1;
            end
            prev = (b == 'hFF);
         end else begin
            if (n == LIMIT) begin
               ovf = 1;
               break;
            end
            fwd.push_back(b);
            n++;
            if (prev && b == 'hD9) begin
               good = 1;
               break;
            end
            prev = (b == 'hFF);
         end
      end
      for (int i = 0; i < fwd.size(); i++)
         byte_q.push_back(fwd[i] | ((good && i == fwd.size() - 1) ? 256 : 0));
      if (ab && cap && !good && !ovf) byte_q.push_back(256);
      nw = ovf ? DEPTH : (good ? (n + 3) / 4 : n / 4);
      for (int w = 0; w < nw; w++) begin
         strb = 15;
         if (good && w == nw - 1 && (n % 4) != 0)
            strb = (15 << (4 - (n % 4))) & 15;
         wr_q.push_back((w << 4) | strb);
      end
      if (good) done_q.push_back(n);

      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
      @(negedge clk);
      for (int i = 0; i < lim; i++) begin
         cam_valid = 1'b1;
         cam_byte  = 8'(stim[i]);
         @(negedge clk);
         cam_valid = 1'b0;
         g = int'($urandom_range(gmax, gmin));
         for (int k = 0; k < g; k++) begin
            if (i == arm_mid && k == 0) arm = 1'b1;
            @(negedge clk);
            arm = 1'b0;
         end
      end
      if (ab) begin
         repeat (12) @(negedge clk);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
      end
      c = 0;
      while (busy && c < 3000) begin
         @(negedge clk);
         c++;
      end
      if (busy) begin
         chk("busy_timeout", int'(busy), 0);
         rst_n = 1'b0;
         byte_q.delete();
         wr_q.delete();
         done_q.delete();
         wq.delete();
         @(negedge clk);
         rst_n = 1'b1;
      end
      repeat (25) @(negedge clk);
      chk("error_out", int'(error), int'(ovf));
      chk("bytes_pending", byte_q.size(), 0);
      chk("writes_pending", wr_q.size(), 0);
      chk("done_pending", done_q.size(), 0);
   endtask

   initial begin : main
      int m;
      int pre;
      int len;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_pack_valid", int'(pack_valid), 0);
      chk("rst_pack_byte", int'(pack_byte), 0);
      chk("rst_complete", int'(pack_complete), 0);
      chk("rst_mem_we", int'(mem_we), 0);
      chk("rst_mem_addr", int'(mem_addr), 0);
      chk("rst_wstrb", int'(mem_wstrb), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_error", int'(error), 0);
      chk("rst_frame_bytes", int'(frame_bytes), 0);

      hold = 2;
      stim = '{'h00, 'hFF, 'hD8, 'h11, 'h22, 'hFF, 'hD9};
      run_frame(-1, 3, 3, -1);
      chk("fb_hold_6", int'(frame_bytes), 6);

      hold = 5;
      stim = '{'hFF, 'hD8, 'h01, 'h02, 'h03, 'h04, 'h05, 'h06, 'h07,
               'hFF, 'hD9};
      run_frame(-1, 3, 3, -1);

      hold = 3;
      stim = '{'hFF, 'hD8, 'hFF, 'h00, 'hFF, 'hD8, 'hAA, 'hFF, 'hFF,
               'hD9};
      run_frame(-1, 1, 3, 4);
      chk("fb_hold_10", int'(frame_bytes), 10);

      hold = 5;
      stim.delete();
      stim.push_back('hFF);
      stim.push_back('hD8);
      for (int i = 0; i < 70; i++) stim.push_back(i & 'h7F);
      run_frame(-1, 3, 3, -1);
      chk("fb_kept_after_ovf", int'(frame_bytes), 10);

      hold = 2;
      stim = '{'hFF, 'hD8, 'h01, 'h02, 'h03, 'h04, 'hFF, 'hD9};
      run_frame(5, 2, 3, -1);
      stim = '{'hFF, 'hD8, 'h31, 'h32, 'h33, 'hFF, 'hD9};
      run_frame(-1, 1, 3, -1);

      arm   = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      arm   = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      chk("arm_abort_idle", int'(busy), 0);

      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
`ifdef JPEG_CAPTURE_TIMEOUT_EN
      repeat (60) @(negedge clk);
      chk("tmo_error", int'(error), 1);
      chk("tmo_busy", int'(busy), 0);
`else
      repeat (1000) @(negedge clk);
      chk("no_tmo_busy", int'(busy), 1);
      chk("no_tmo_error", int'(error), 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      @(negedge clk);
      chk("hunt_abort_busy", int'(busy), 0);
`endif

      for (int it = 0; it < 16; it++) begin
         m    = int'($urandom_range(3, 0));
         hold = int'($urandom_range(4, 1));
         pre  = int'($urandom_range(3, 0));
         case (m)
            0: begin
               mk(pre, int'($urandom_range(40, 0)));
               run_frame(-1, 1, 3, -1);
            end
            1: begin
               mk(pre, int'($urandom_range(80, 66)));
               run_frame(-1, 1, 3, -1);
            end
            2: begin
               len = int'($urandom_range(20, 6));
               mk(pre, len);
               run_frame(pre + 2 + int'($urandom_range(len, 3)), 1, 3, -1);
            end
            default: begin
               mk(pre, 10);
               run_frame(pre, 1, 3, -1);
            end
         endcase
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
